// File: rtl/aes128_encrypt_iter.sv
// +--------------------------------------------------------------------------+
// | Module  : aes128_encrypt_iter                                            |
// | Purpose : Iterative AES-128 forward cipher, one round per clock, with    |
// |           on-the-fly key expansion. Optional macro AES_ENC_KEY_OUT_EN    |
// |           exposes the round-10 key on last_rk.                           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module aes128_encrypt_iter (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] pt_in,
  input  logic [0:127] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] ct_out,
  output logic         busy
`ifdef AES_ENC_KEY_OUT_EN
  ,
  output logic [0:127] last_rk
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] C_LAST_RND = 4'd10;

  localparam logic [0:2047] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    sbox = C_SBOX[{x, 3'b000} +: 8];
  endfunction

  // Multiply by 02 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  state_t         state_q, state_d;
  logic [0:127]   st_q, st_d;
  logic [0:127]   rk_q, rk_d;
  logic [3:0]     rnd_q, rnd_d;

  logic [7:0]     sb_w  [16];
  logic [7:0]     sr_w  [16];
  logic [7:0]     mc_w  [16];
  logic [7:0]     rkn_w [16];
  logic [7:0]     tmp_w [4];
  logic [0:127]   rk_next_w;
  logic [0:127]   mid_rnd_w;
  logic [0:127]   last_rnd_w;

  genvar k, r, c;

  generate
    for (k = 0; k < 16; k++) begin : g_sub
      assign sb_w[k] = sbox(st_q[8*k +: 8]);
    end

    // Byte k sits at row k%4, column k/4; row r rotates left by r.
    for (r = 0; r < 4; r++) begin : g_shift_row
      for (c = 0; c < 4; c++) begin : g_shift_col
        assign sr_w[r + 4*c] = sb_w[r + 4*((c + r) % 4)];
      end
    end

    for (c = 0; c < 4; c++) begin : g_mix
      assign mc_w[4*c+0] = xt(sr_w[4*c+0]) ^ xt(sr_w[4*c+1]) ^ sr_w[4*c+1] ^ sr_w[4*c+2] ^ sr_w[4*c+3];
      assign mc_w[4*c+1] = sr_w[4*c+0] ^ xt(sr_w[4*c+1]) ^ xt(sr_w[4*c+2]) ^ sr_w[4*c+2] ^ sr_w[4*c+3];
      assign mc_w[4*c+2] = sr_w[4*c+0] ^ sr_w[4*c+1] ^ xt(sr_w[4*c+2]) ^ xt(sr_w[4*c+3]) ^ sr_w[4*c+3];
      assign mc_w[4*c+3] = xt(sr_w[4*c+0]) ^ sr_w[4*c+0] ^ sr_w[4*c+1] ^ sr_w[4*c+2] ^ xt(sr_w[4*c+3]);
    end
  endgenerate

  // SubWord(RotWord(w3)) ^ rcon, where w3 is bytes 12..15.
  assign tmp_w[0] = sbox(rk_q[8*13 +: 8]) ^ rcon(rnd_q);
  assign tmp_w[1] = sbox(rk_q[8*14 +: 8]);
  assign tmp_w[2] = sbox(rk_q[8*15 +: 8]);
  assign tmp_w[3] = sbox(rk_q[8*12 +: 8]);

  generate
    for (k = 0; k < 4; k++) begin : g_kexp_w0
      assign rkn_w[k] = rk_q[8*k +: 8] ^ tmp_w[k];
    end
    for (k = 4; k < 16; k++) begin : g_kexp_wn
      assign rkn_w[k] = rk_q[8*k +: 8] ^ rkn_w[k-4];
    end

    for (k = 0; k < 16; k++) begin : g_pack
      assign rk_next_w[8*k +: 8]  = rkn_w[k];
      assign mid_rnd_w[8*k +: 8]  = mc_w[k] ^ rkn_w[k];
      assign last_rnd_w[8*k +: 8] = sr_w[k] ^ rkn_w[k];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      rk_q    <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    rk_d    = rk_q;
    rnd_d   = rnd_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          st_d    = pt_in ^ key_in;
          rk_d    = key_in;
          rnd_d   = 4'd1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        rk_d = rk_next_w;
        if (rnd_q == C_LAST_RND) begin
          st_d    = last_rnd_w;
          rnd_d   = 4'd0;
          state_d = S_DONE;
        end else begin
          st_d  = mid_rnd_w;
          rnd_d = rnd_q + 4'd1;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign ct_out    = st_q;
`ifdef AES_ENC_KEY_OUT_EN
  assign last_rk   = rk_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_aes128_encrypt_iter.sv
// +--------------------------------------------------------------------------+
// | Module  : tb_aes128_encrypt_iter                                         |
// | Purpose : Scoreboard bench for aes128_encrypt_iter with FIPS-197 vectors.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_aes128_encrypt_iter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] pt_in = '0;
  logic [0:127] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [0:127] ct_out;
  logic         busy;
`ifdef AES_ENC_KEY_OUT_EN
  logic [0:127] last_rk;
`endif

  aes128_encrypt_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .pt_in     (pt_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ct_out    (ct_out),
    .busy      (busy)
`ifdef AES_ENC_KEY_OUT_EN
    ,
    .last_rk   (last_rk)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] R1  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P2  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C2  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R2  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] rk;
    int           hs;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out or unexpected event (cycle %0d)", name, cyc);
  endtask

  task automatic monitor();
    bit           prev_v = 1'b0;
    bit           hold_v = 1'b0;
    logic [127:0] held = '0;
    exp_t         e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        hold_v = 1'b0;
      end else begin
        if (out_valid && !prev_v) begin
          if (q.size() == 0) fail_now("unexpected_out_valid");
          else chk("latency", 128'(cyc - q[0].hs), 128'd10);
        end
        if (out_valid && hold_v) chk("ct_stable", ct_out, held);
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            fail_now("unexpected_output");
          end else begin
            e = q.pop_front();
            chk("ct_out", ct_out, e.ct);
`ifdef AES_ENC_KEY_OUT_EN
            chk("last_rk", last_rk, e.rk);
`endif
          end
          hold_v = 1'b0;
        end else if (out_valid) begin
          held   = ct_out;
          hold_v = 1'b1;
        end else begin
          hold_v = 1'b0;
        end
        prev_v = out_valid;
      end
    end
  endtask

  // Offers a block and records the expected result at the handshake edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct,
                      input logic [127:0] rk, input bit hold, output int hs);
    int n;
    n        = 0;
    hs       = -1;
    pt_in    = pt;
    key_in   = key;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("in_ready_wait");
      in_valid = 1'b0;
    end else begin
      hs = cyc + 1;
      q.push_back('{ct: ct, rk: rk, hs: hs});
      @(posedge clk);
      #1;
      if (!hold) in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      fail_now("drain");
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int h1, h2, n;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ct_out", ct_out, 128'd0);
`ifdef AES_ENC_KEY_OUT_EN
    chk("rst_last_rk", last_rk, 128'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1 and 2: single blocks
    send(P1, K1, C1, R1, 1'b0, h1);
    @(negedge clk);
    chk("busy_in_run", 128'(busy), 128'd1);
    chk("in_ready_in_run", 128'(in_ready), 128'd0);
    drain();
    send(P2, K2, C2, R2, 1'b0, h1);
    drain();

    // Test 3: backpressure
    out_ready = 1'b0;
    send(P1, K1, C1, R1, 1'b0, h1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("wait_out_valid");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      pt_in    = {$urandom, $urandom, $urandom, $urandom};
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_in_ready", 128'(in_ready), 128'd1);
    chk("bp_idle_busy", 128'(busy), 128'd0);
    chk("bp_idle_out_valid", 128'(out_valid), 128'd0);
    drain();

    // Test 4: back-to-back
    send(P1, K1, C1, R1, 1'b1, h1);
    send(P2, K2, C2, R2, 1'b0, h2);
    chk("b2b_spacing", 128'(h2 - h1), 128'd12);
    drain();

    // Test 5: inputs changed during RUN
    send(P1, K1, C1, R1, 1'b0, h1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      pt_in    = {$urandom, $urandom, $urandom, $urandom};
      key_in   = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Test 6: reset mid-run, then a fresh block
    send(P1, K1, C1, R1, 1'b0, h1);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    q.delete();
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_ct_out", ct_out, 128'd0);
    repeat (2) @(negedge clk);
    chk("mid_rst_hold_out_valid", 128'(out_valid), 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(P2, K2, C2, R2, 1'b0, h1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
